load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Core-side initiator for the word-addressed data memory. It accepts byte-addressed RV32I load/store requests from the execute stage over a valid/ready handshake. It translates each request into memory word address, write strobe code and write data, and extracts plus sign/zero-extends load data from the memory's asynchronous read port. It sits between the core pipeline and the data memory and returns one response per request.

Parameters:
DEPTH, 128, number of 32-bit words in the attached data memory; word address width AW = $clog2(DEPTH).

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  access faulted, no memory side effect
mem_rd_addr  output  AW  word address for memory read port
mem_rd_data  input  32  asynchronous read data from memory
mem_wr_addr  output  AW  word address for memory write port
mem_wr_data  output  32  write data
mem_we  output  1  write enable
mem_wr_strb  output  3  strobe code: 000 word, 001 low half, 011 high half, 1kk byte kk, 010 nop

Behaviour:
- FSM states IDLE, ACCESS, RESP.
- IDLE: req_ready=1. When req_valid&&req_ready on an edge, register we/funct3/addr/wdata and go to ACCESS.
- ACCESS: exactly one cycle; req_ready=0. mem_rd_addr=mem_wr_addr=addr[AW+1:2].
  - Store without error: mem_we=1 for this cycle only; mem_wr_data=wdata unshifted.
  - Store strobe: SW→000; SH→001 if addr[1]=0, else 011; SB→{1'b1,addr[1:0]}.
  - Load: sample mem_rd_data, shift right by 8*addr[1:0], then sign-extend (B/H) or zero-extend (BU/HU/W) into the resp_rdata register.
  - Always go to RESP.
- RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready=1, then go to IDLE. There is no request acceptance in RESP.
- Latency: request accepted at edge N; memory write at edge N+1; resp_valid high from after edge N+1. Minimum 3 cycles per request.
- Outside ACCESS: mem_we=0 and mem_wr_strb=010 (nop).
- Errors (resp_err=1, mem_we never asserted, resp_rdata=0):
  - Out of range: req_addr[31:AW+2]≠0.
  - Illegal funct3: loads 011/110/111; stores other than 000/001/010.
  - Misaligned access (see feature below).
- Error requests still traverse ACCESS so latency is uniform.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_wr_strb=010, mem addresses 0, mem_wr_data 0.
- Reset during ACCESS or RESP: return to IDLE immediately; mem_we drops asynchronously; the pending response is discarded.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: halfword access with addr[0]=1, or word access with addr[1:0]≠0, produces resp_err=1 with no write.
- Undefined: misalignment is not an error. Halfword uses addr[1] only (addr[0] ignored). Word uses addr[1:0]=00. Range and funct3 errors still apply.

Test Plan:
- Reset, SW addr 0x8 data 0xDEADBEEF → during ACCESS mem_we=1, mem_wr_addr=2, strb=000, data 0xDEADBEEF; resp err=0. Then LW 0x8 → rdata 0xDEADBEEF.
- SB addr 0xB data 0x000000A5 → strb=111, wr_addr=2, memory word becomes 0xA5ADBEEF. LB 0xB → 0xFFFFFFA5; LBU 0xB → 0x000000A5.
- LH 0xA → 0xFFFFA5AD; LHU 0x8 → 0x0000BEEF; SH 0xA data 0x1234 → strb=011.
- Hold resp_ready=0 for 5 cycles after a load → resp_valid, rdata and err stable, req_ready=0, second request not accepted; it is accepted the cycle after the handshake completes.
- SW addr 0x200 (DEPTH=128) → mem_we stays 0, resp_err=1, rdata 0. LW 0x6: with MISALIGN_TRAP_EN, err=1; without it, returns word 1 contents with err=0.
- Assert rst low mid-ACCESS of a store → mem_we=0 immediately, no resp_valid, req_ready=1 after release.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-addressed data memory with an asynchronous read port.
// Define MISALIGN_TRAP_EN to make misaligned halfword/word accesses fault instead of being truncated.
module load_store_unit #(
    parameter int DEPTH = 128,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [31:0]   mem_rd_data,
    output logic [AW-1:0] mem_wr_addr,
    output logic [31:0]   mem_wr_data,
    output logic          mem_we,
    output logic [2:0]    mem_wr_strb
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [2:0] STRB_NOP = 3'b010;

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;
    logic        err_q;

    logic        range_err;
    logic        funct3_err;
    logic        misalign_err;
    logic        req_err;
    logic [1:0]  req_off;
    logic [2:0]  store_strb;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Request decode, evaluated on the raw request so faults are known at acceptance.
    always_comb begin
        range_err    = |req_addr[31:AW+2];
        funct3_err   = 1'b0;
        misalign_err = 1'b0;
        req_off      = 2'b00;
        store_strb   = 3'b000;

        if (req_we)
            funct3_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            funct3_err = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});

`ifdef MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'b01:   misalign_err = req_addr[0];
            2'b10:   misalign_err = |req_addr[1:0];
            default: misalign_err = 1'b0;
        endcase
`else
        misalign_err = 1'b0;
`endif

        // Without trapping, halfwords drop addr[0] and words drop addr[1:0].
        case (req_funct3[1:0])
            2'b00:   req_off = req_addr[1:0];
            2'b01:   req_off = {req_addr[1], 1'b0};
            default: req_off = 2'b00;
        endcase

        case (req_funct3[1:0])
            2'b00:   store_strb = {1'b1, req_off};
            2'b01:   store_strb = {1'b0, req_off[1], 1'b1};
            default: store_strb = 3'b000;
        endcase

        req_err = range_err | funct3_err | misalign_err;
    end

    // Load data alignment and extension, from the memory's asynchronous read port.
    always_comb begin
        shifted = mem_rd_data >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            err_q       <= 1'b0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            resp_err    <= 1'b0;
            mem_rd_addr <= '0;
            mem_wr_addr <= '0;
            mem_wr_data <= 32'd0;
            mem_we      <= 1'b0;
            mem_wr_strb <= STRB_NOP;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state       <= ACCESS;
                        req_ready   <= 1'b0;
                        we_q        <= req_we;
                        funct3_q    <= req_funct3;
                        off_q       <= req_off;
                        err_q       <= req_err;
                        mem_rd_addr <= req_addr[AW+1:2];
                        mem_wr_addr <= req_addr[AW+1:2];
                        mem_wr_data <= req_wdata;
                        // Write strobe and enable are registered so they are live for ACCESS only.
                        mem_we      <= req_we && !req_err;
                        mem_wr_strb <= (req_we && !req_err) ? store_strb : STRB_NOP;
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    mem_we      <= 1'b0;
                    mem_wr_strb <= STRB_NOP;
                    resp_valid  <= 1'b1;
                    resp_err    <= err_q;
                    resp_rdata  <= (err_q || we_q) ? 32'd0 : load_ext;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    mem_we     <= 1'b0;
                end
            endcase
        end
    end

endmodule
